// File: rtl/i2s_receiver_pkg.sv
// Shared constants and FSM state encoding for the I2S receive path.
// i2s_master uses the same width constants.
package i2s_receiver_pkg;

    localparam int I2S_DATA_WIDTH  = 24;
    localparam int I2S_SLOT_WIDTH  = 32;
    localparam int I2S_FIFO_DEPTH  = 4;
    localparam int I2S_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        RX_LEFT   = 2'd1,
        RX_RIGHT  = 2'd2
    } rx_state_e;

endpackage

// File: rtl/i2s_receiver_rx_fifo.sv
// Synchronous first-word-fall-through FIFO for completed stereo frames.
// The head register is read at the next read pointer, bypassing a same-cycle write.
module i2s_rx_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     fill_level_o,
    output logic                       drop_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] head_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [LVL_W-1:0] count_q;
    logic             full;
    logic             empty;
    logic             push_ok;
    logic             pop_ok;

    assign empty    = (count_q == '0);
    assign full     = (count_q == LVL_W'(DEPTH));
    assign pop_ok   = pop_i & ~empty;
    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    assign push_ok  = push_i & (~full | pop_ok);
    assign drop_o   = push_i & full & ~pop_ok;
    assign rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok && !srst) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            head_q <= '0;
        end else if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
            head_q <= wdata_i;
        end else begin
            head_q <= mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            rd_ptr_q <= rd_ptr_d;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + LVL_W'(1);
                2'b01:   count_q <= count_q - LVL_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata_o      = head_q;
    assign empty_o      = empty;
    assign fill_level_o = count_q;

endmodule

// File: rtl/i2s_receiver.sv
// I2S ADC-stream deserialiser: oversamples bclk/lrclk/sdata in the clk_soc domain,
// assembles left/right words and buffers completed frames in an FWFT FIFO.
module i2s_receiver
    import i2s_receiver_pkg::*;
#(
    parameter int DATA_WIDTH  = I2S_DATA_WIDTH,
    parameter int SLOT_WIDTH  = I2S_SLOT_WIDTH,
    parameter int FIFO_DEPTH  = I2S_FIFO_DEPTH,
    parameter int SYNC_STAGES = I2S_SYNC_STAGES
) (
    input  logic                          clk_soc,
    input  logic                          reset,
    input  logic                          bclk,
    input  logic                          lrclk,
    input  logic                          sdata,
    output logic [DATA_WIDTH-1:0]         frame_out_l,
    output logic [DATA_WIDTH-1:0]         frame_out_r,
    input  logic                          read_frame,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic                          overflow,
    output logic                          framing_err,
    input  logic                          clear_flags
);

    localparam int CNT_W = $clog2(SLOT_WIDTH + 1);
    localparam logic [CNT_W-1:0] DW_CNT   = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] SLOT_CNT = CNT_W'(SLOT_WIDTH);

    logic [SYNC_STAGES-1:0] bclk_sync_q;
    logic [SYNC_STAGES-1:0] lr_sync_q;
    logic [SYNC_STAGES-1:0] sd_sync_q;
    logic                   bclk_prev_q;
    logic                   lr_prev_q;

    rx_state_e              state_q;
    logic [CNT_W-1:0]       bit_cnt_q;
    logic [DATA_WIDTH-1:0]  shift_q;
    logic [DATA_WIDTH-1:0]  left_q;
    logic                   push_q;
    logic                   overflow_q;
    logic                   framing_err_q;

    logic                   bclk_rise;
    logic                   lr;
    logic                   sd;
    logic                   boundary;
    logic                   shifting;
    logic                   word_done;
    logic                   word_ok;
    logic [DATA_WIDTH-1:0]  shift_in;
    logic                   fifo_drop;

    // All three pins share the same chain depth so their relative alignment survives.
    always_ff @(posedge clk_soc) begin
        if (reset) begin
            bclk_sync_q <= '0;
            lr_sync_q   <= '0;
            sd_sync_q   <= '0;
            bclk_prev_q <= 1'b0;
        end else begin
            bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], bclk};
            lr_sync_q   <= {lr_sync_q[SYNC_STAGES-2:0], lrclk};
            sd_sync_q   <= {sd_sync_q[SYNC_STAGES-2:0], sdata};
            bclk_prev_q <= bclk_sync_q[SYNC_STAGES-1];
        end
    end

    assign lr        = lr_sync_q[SYNC_STAGES-1];
    assign sd        = sd_sync_q[SYNC_STAGES-1];
    assign bclk_rise = bclk_sync_q[SYNC_STAGES-1] & ~bclk_prev_q;
    assign boundary  = (lr != lr_prev_q);
    assign shifting  = !boundary && (bit_cnt_q < DW_CNT);
    assign word_done = shifting && (bit_cnt_q == LAST_CNT);
    assign word_ok   = (bit_cnt_q >= DW_CNT);
    assign shift_in  = {shift_q[DATA_WIDTH-2:0], sd};

    always_ff @(posedge clk_soc) begin
        if (reset) begin
            state_q       <= WAIT_SYNC;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            left_q        <= '0;
            lr_prev_q     <= 1'b0;
            push_q        <= 1'b0;
            framing_err_q <= 1'b0;
        end else begin
            push_q <= 1'b0;
            // Later set assignments below override this clear when both happen.
            if (clear_flags) begin
                framing_err_q <= 1'b0;
            end
            if (bclk_rise) begin
                lr_prev_q <= lr;
                // The boundary edge carries the previous slot's LSB, so it is dropped.
                if (boundary) begin
                    bit_cnt_q <= '0;
                end else if (shifting) begin
                    shift_q   <= shift_in;
                    bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                end else if (bit_cnt_q < SLOT_CNT) begin
                    bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                end

                case (state_q)
                    WAIT_SYNC: begin
                        if (boundary && !lr) begin
                            state_q <= RX_LEFT;
                        end
                    end
                    RX_LEFT: begin
                        if (word_done) begin
                            left_q <= shift_in;
                        end
                        if (boundary && lr) begin
                            if (word_ok) begin
                                state_q <= RX_RIGHT;
                            end else begin
                                framing_err_q <= 1'b1;
                                state_q       <= WAIT_SYNC;
                            end
                        end
                    end
                    RX_RIGHT: begin
                        if (word_done) begin
                            push_q <= 1'b1;
                        end
                        // A short right slot still restarts the left slot on this edge.
                        if (boundary && !lr) begin
                            if (!word_ok) begin
                                framing_err_q <= 1'b1;
                            end
                            state_q <= RX_LEFT;
                        end
                    end
                    default: state_q <= WAIT_SYNC;
                endcase
            end
        end
    end

    always_ff @(posedge clk_soc) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (fifo_drop) begin
            overflow_q <= 1'b1;
        end else if (clear_flags) begin
            overflow_q <= 1'b0;
        end
    end

    // shift_q holds the finished right word for the cycle push_q is high.
    i2s_rx_fifo #(
        .WIDTH (2 * DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk_soc),
        .srst         (reset),
        .push_i       (push_q),
        .wdata_i      ({left_q, shift_q}),
        .pop_i        (read_frame),
        .rdata_o      ({frame_out_l, frame_out_r}),
        .empty_o      (empty),
        .fill_level_o (fill_level),
        .drop_o       (fifo_drop)
    );

    assign overflow    = overflow_q;
    assign framing_err = framing_err_q;

endmodule

// File: tb/tb_i2s_receiver.sv
// Scoreboard bench for i2s_receiver: directed I2S frames, expected frames queued
// at issue time, a monitor compares the FIFO head on every accepted read_frame.
`timescale 1ns/1ps
module tb_i2s_receiver;

    localparam int DW    = 24;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;
    localparam int LVL_W = 3;
    localparam int HALF  = 195;

    logic           clk_soc     = 1'b0;
    logic           reset       = 1'b1;
    logic           bclk        = 1'b1;
    logic           lrclk       = 1'b1;
    logic           sdata       = 1'b0;
    logic           read_frame  = 1'b0;
    logic           clear_flags = 1'b0;
    logic [DW-1:0]  frame_out_l;
    logic [DW-1:0]  frame_out_r;
    logic           empty;
    logic [LVL_W-1:0] fill_level;
    logic           overflow;
    logic           framing_err;

    int checks   = 0;
    int failures = 0;
    logic [2*DW-1:0] exp_q[$];
    logic [2*DW-1:0] exp_frame;
    event right_last_ev;

    always #5 clk_soc = ~clk_soc;

    i2s_receiver dut (
        .clk_soc     (clk_soc),
        .reset       (reset),
        .bclk        (bclk),
        .lrclk       (lrclk),
        .sdata       (sdata),
        .frame_out_l (frame_out_l),
        .frame_out_r (frame_out_r),
        .read_frame  (read_frame),
        .empty       (empty),
        .fill_level  (fill_level),
        .overflow    (overflow),
        .framing_err (framing_err),
        .clear_flags (clear_flags)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted pop is compared against the oldest expected frame.
    always @(negedge clk_soc) begin
        if (read_frame && !empty) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pop_unexpected: got %h_%h, expected no frame", frame_out_l, frame_out_r);
            end else begin
                exp_frame = exp_q.pop_front();
                check("pop_frame", 64'({frame_out_l, frame_out_r}), 64'(exp_frame));
                $display("pop l=%h r=%h", frame_out_l, frame_out_r);
            end
        end
    end

    task automatic bclk_cycle(input logic lr, input logic sd, input logic mark);
        bclk  = 1'b0;
        lrclk = lr;
        sdata = sd;
        #HALF;
        bclk = 1'b1;
        if (mark) -> right_last_ev;
        #HALF;
    endtask

    // Standard I2S: bit k=0 of a slot is the previous slot's LSB, k=1..DW carry MSB..LSB.
    task automatic send_slot(input logic lr, input logic [DW-1:0] data, input int nbits);
        for (int k = 0; k < nbits; k++) begin
            logic b;
            b = (k >= 1 && k <= DW) ? data[DW-k] : 1'b0;
            bclk_cycle(lr, b, lr && (k == DW));
        end
    endtask

    // Keeps raw bclk edges 2 ns off any clk_soc edge (mod 10 ns = 2 or 7).
    task automatic align();
        @(posedge clk_soc);
        #7;
    endtask

    task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
        align();
        send_slot(1'b0, l, 32);
        send_slot(1'b1, r, 32);
        $display("sent frame l=%h r=%h", l, r);
    endtask

    task automatic idle(input int n);
        align();
        for (int i = 0; i < n; i++) bclk_cycle(1'b1, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) begin
            @(posedge clk_soc);
            #1;
            if (empty) break;
            read_frame = 1'b1;
            @(posedge clk_soc);
            #1;
            read_frame = 1'b0;
        end
    endtask

    task automatic pulse_clear();
        @(posedge clk_soc);
        #1 clear_flags = 1'b1;
        @(posedge clk_soc);
        #1 clear_flags = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk_soc);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk_soc);
        #1 reset = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached, expected summary before it");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        logic [2*DW-1:0] head_at_lat;

        // Reset values
        do_reset();
        @(negedge clk_soc);
        check("rst_empty", 64'(empty), 64'(1));
        check("rst_fill", 64'(fill_level), 64'(0));
        check("rst_overflow", 64'(overflow), 64'(0));
        check("rst_framing", 64'(framing_err), 64'(0));
        check("rst_frame_out", 64'({frame_out_l, frame_out_r}), 64'(0));

        // 1: single frame, latency and FWFT data
        idle(4);
        exp_q.push_back({24'hA5A5A5, 24'h123456});
        lat = 0;
        head_at_lat = '0;
        fork
            send_frame(24'hA5A5A5, 24'h123456);
            begin
                @(right_last_ev);
                for (int i = 1; i <= 20 && lat == 0; i++) begin
                    @(posedge clk_soc);
                    #1;
                    if (!empty) begin
                        lat = i;
                        head_at_lat = {frame_out_l, frame_out_r};
                    end
                end
            end
        join
        check("t1_latency", 64'(lat), 64'(SYNC + 2));
        check("t1_head_at_empty_fall", 64'(head_at_lat), 64'({24'hA5A5A5, 24'h123456}));
        @(negedge clk_soc);
        check("t1_fill", 64'(fill_level), 64'(1));
        drain();
        @(negedge clk_soc);
        check("t1_empty_after_read", 64'(empty), 64'(1));
        check("t1_scoreboard", 64'(exp_q.size()), 64'(0));

        // 2: stream begins mid right slot
        do_reset();
        align();
        send_slot(1'b1, 24'hFFFFFF, 20);
        @(negedge clk_soc);
        check("t2_no_push_partial", 64'(fill_level), 64'(0));
        exp_q.push_back({24'h3C3C3C, 24'hC3C3C3});
        send_frame(24'h3C3C3C, 24'hC3C3C3);
        @(negedge clk_soc);
        check("t2_fill", 64'(fill_level), 64'(1));
        drain();
        check("t2_scoreboard", 64'(exp_q.size()), 64'(0));

        // 3: five frames without reads, FIFO depth four
        exp_q.push_back({24'h100001, 24'h200002});
        exp_q.push_back({24'h300003, 24'h400004});
        exp_q.push_back({24'h500005, 24'h600006});
        exp_q.push_back({24'h700007, 24'h800008});
        send_frame(24'h100001, 24'h200002);
        send_frame(24'h300003, 24'h400004);
        send_frame(24'h500005, 24'h600006);
        send_frame(24'h700007, 24'h800008);
        @(negedge clk_soc);
        check("t3_overflow_before_drop", 64'(overflow), 64'(0));
        send_frame(24'h900009, 24'hA0000A);
        @(negedge clk_soc);
        check("t3_fill", 64'(fill_level), 64'(4));
        check("t3_overflow", 64'(overflow), 64'(1));
        check("t3_head", 64'({frame_out_l, frame_out_r}), 64'({24'h100001, 24'h200002}));
        pulse_clear();
        @(negedge clk_soc);
        check("t3_overflow_cleared", 64'(overflow), 64'(0));
        check("t3_fill_after_clear", 64'(fill_level), 64'(4));

        // 4: full FIFO, read in the push cycle
        exp_q.push_back({24'hB0000B, 24'hC0000C});
        fork
            send_frame(24'hB0000B, 24'hC0000C);
            begin
                @(right_last_ev);
                repeat (SYNC + 1) @(posedge clk_soc);
                #1 read_frame = 1'b1;
                @(posedge clk_soc);
                #1 read_frame = 1'b0;
            end
        join
        @(negedge clk_soc);
        check("t4_fill", 64'(fill_level), 64'(4));
        check("t4_overflow", 64'(overflow), 64'(0));
        check("t4_head", 64'({frame_out_l, frame_out_r}), 64'({24'h300003, 24'h400004}));
        drain();
        check("t4_scoreboard", 64'(exp_q.size()), 64'(0));

        // 5: truncated left slot
        align();
        send_slot(1'b0, 24'h0F0F0F, 10);
        send_slot(1'b1, 24'hAAAAAA, 32);
        @(negedge clk_soc);
        check("t5_framing", 64'(framing_err), 64'(1));
        check("t5_no_push", 64'(fill_level), 64'(0));
        exp_q.push_back({24'h5A5A5A, 24'h0F00F1});
        send_frame(24'h5A5A5A, 24'h0F00F1);
        @(negedge clk_soc);
        check("t5_fill", 64'(fill_level), 64'(1));
        pulse_clear();
        @(negedge clk_soc);
        check("t5_framing_cleared", 64'(framing_err), 64'(0));
        drain();
        check("t5_scoreboard", 64'(exp_q.size()), 64'(0));

        // 6: reset mid right slot with two frames buffered
        send_frame(24'h111111, 24'h222222);
        send_frame(24'h333333, 24'h444444);
        @(negedge clk_soc);
        check("t6_fill_before", 64'(fill_level), 64'(2));
        align();
        send_slot(1'b0, 24'h555555, 32);
        send_slot(1'b1, 24'h666666, 12);
        @(posedge clk_soc);
        #1 reset = 1'b1;
        @(posedge clk_soc);
        #1;
        check("t6_empty_after_reset", 64'(empty), 64'(1));
        check("t6_fill_after_reset", 64'(fill_level), 64'(0));
        reset = 1'b0;
        idle(4);
        exp_q.push_back({24'hDEADBE, 24'hEF0123});
        send_frame(24'hDEADBE, 24'hEF0123);
        @(negedge clk_soc);
        check("t6_fill_resync", 64'(fill_level), 64'(1));
        drain();
        check("t6_scoreboard", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
